// File: rtl/matmul_top.sv
// 2x2 signed matrix multiplier: operands captured on start, two MAC cycles, then a registered write of C with a one-cycle done pulse.
// Define MATMUL_SAT_EN to saturate the result to the ACC_W range instead of wrapping modulo 2^ACC_W.
module matmul_top #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] A [2][2],
    input  logic signed [DATA_W-1:0] B [2][2],
    output logic signed [ACC_W-1:0]  C [2][2],
    output logic                     done
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 1;
    localparam int EXT_W  = (ACC_W > SUM_W) ? ACC_W : SUM_W;

`ifdef MATMUL_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t state, state_next;
    logic [1:0] k;
    logic signed [DATA_W-1:0] a_reg [2][2];
    logic signed [DATA_W-1:0] b_reg [2][2];
    logic signed [SUM_W-1:0]  acc   [2][2];
    logic signed [PROD_W-1:0] prod  [2][2];
    logic signed [EXT_W-1:0]  ext   [2][2];
    logic signed [ACC_W-1:0]  c_conv [2][2];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COMPUTE;
            COMPUTE: if (k == 2'd2) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The k=2 cycle of COMPUTE is the write-back slot; its products are discarded.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                prod[i][j] = PROD_W'(a_reg[i][k[0]]) * PROD_W'(b_reg[k[0]][j]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                ext[i][j] = EXT_W'(acc[i][j]);
`ifdef MATMUL_SAT_EN
                if (ext[i][j] > SAT_MAX)
                    c_conv[i][j] = SAT_MAX[ACC_W-1:0];
                else if (ext[i][j] < SAT_MIN)
                    c_conv[i][j] = SAT_MIN[ACC_W-1:0];
                else
                    c_conv[i][j] = ext[i][j][ACC_W-1:0];
`else
                c_conv[i][j] = ext[i][j][ACC_W-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            k     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                    C[i][j]     <= '0;
                end
            end
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k <= 2'd0;
                        for (int i = 0; i < 2; i++) begin
                            for (int j = 0; j < 2; j++) begin
                                a_reg[i][j] <= A[i][j];
                                b_reg[i][j] <= B[i][j];
                                acc[i][j]   <= '0;
                            end
                        end
                    end
                end
                COMPUTE: begin
                    if (k == 2'd2) begin
                        done <= 1'b1;
                        for (int i = 0; i < 2; i++) begin
                            for (int j = 0; j < 2; j++) begin
                                C[i][j] <= c_conv[i][j];
                            end
                        end
                    end else begin
                        k <= k + 2'd1;
                        for (int i = 0; i < 2; i++) begin
                            for (int j = 0; j < 2; j++) begin
                                acc[i][j] <= acc[i][j] + SUM_W'(prod[i][j]);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_top.sv
// Directed bench for matmul_top: a scoreboard queue holds expected C values, popped when done pulses.
// A second instance with ACC_W=8 exercises the wrap/saturate output conversion (MATMUL_SAT_EN).
module tb_matmul_top;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [7:0]  A  [2][2];
    logic signed [7:0]  B  [2][2];
    logic signed [31:0] C  [2][2];
    logic signed [7:0]  C8 [2][2];
    logic done;
    logic done8;

    int tests = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    matmul_top dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C(C), .done(done)
    );

    matmul_top #(.DATA_W(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C(C8), .done(done8)
    );

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drives operands and start at a negedge; the model result goes on the queue when push is set.
    task automatic applyStimulus(input int a00, input int a01, input int a10, input int a11,
                                 input int b00, input int b01, input int b10, input int b11,
                                 input bit push);
        A[0][0] = 8'(a00); A[0][1] = 8'(a01); A[1][0] = 8'(a10); A[1][1] = 8'(a11);
        B[0][0] = 8'(b00); B[0][1] = 8'(b01); B[1][0] = 8'(b10); B[1][1] = 8'(b11);
        start = 1'b1;
        if (push) begin
            exp_q.push_back(a00 * b00 + a01 * b10);
            exp_q.push_back(a00 * b01 + a01 * b11);
            exp_q.push_back(a10 * b00 + a11 * b10);
            exp_q.push_back(a10 * b01 + a11 * b11);
        end
    endtask

    task automatic waitDone(input string tag, input int want_lat, input bit drop_start);
        int n;
        bit seen;
        int e;
        n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1 && drop_start) start = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput({tag, " latency"}, n, want_lat);
        checkOutput({tag, " done8"}, done8, 1);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                checkOutput($sformatf("%s C[%0d][%0d]", tag, i, j), C[i][j], e);
            end
        end
        @(negedge clk);
        checkOutput({tag, " done one cycle"}, done, 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                A[i][j] = '0;
                B[i][j] = '0;
            end
        end
        repeat (2) @(negedge clk);
        checkOutput("reset done", done, 0);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                checkOutput($sformatf("reset C[%0d][%0d]", i, j), C[i][j], 0);
                checkOutput($sformatf("reset C8[%0d][%0d]", i, j), C8[i][j], 0);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle no start done", done, 0);

        $display("[TB] basic product");
        applyStimulus(1, 2, 3, 4, 5, 6, 7, 8, 1'b1);
        waitDone("basic", 4, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("hold C[1][1]", C[1][1], 50);
        checkOutput("hold done", done, 0);

        $display("[TB] most negative operands");
        applyStimulus(-128, -128, -128, -128, -128, -128, -128, -128, 1'b1);
        waitDone("neg", 4, 1'b1);

        $display("[TB] identity");
        applyStimulus(-1, 2, 3, -4, 1, 0, 0, 1, 1'b1);
        waitDone("ident", 4, 1'b1);
        @(negedge clk);

        $display("[TB] back-to-back with operand change during compute");
        applyStimulus(2, -3, 5, 7, 1, 4, -6, 2, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(10, 20, -30, 40, 3, -1, 2, 5, 1'b1);
        waitDone("b2b first", 2, 1'b0);
        waitDone("b2b second", 4, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset abort");
        applyStimulus(9, 9, 9, 9, 9, 9, 9, 9, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0) cnt++;
        end
        checkOutput("abort done pulses", cnt, 0);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                checkOutput($sformatf("abort C[%0d][%0d]", i, j), C[i][j], 0);
            end
        end

        $display("[TB] narrow accumulator conversion");
        applyStimulus(127, 127, 127, 127, 127, 127, 127, 127, 1'b1);
        waitDone("max", 4, 1'b1);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
`ifdef MATMUL_SAT_EN
                checkOutput($sformatf("narrow C8[%0d][%0d]", i, j), C8[i][j], 127);
`else
                checkOutput($sformatf("narrow C8[%0d][%0d]", i, j), C8[i][j], 2);
`endif
            end
        end
        checkOutput("scoreboard empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
